// File: rtl/canvas_pkg.sv
// Shared grid constants, FSM state encoding and the bitmap index helper
// for the handwriting canvas.
package canvas_pkg;
  localparam int GRID      = 30;
  localparam int GRID_BITS = 900;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAINT,
    ST_CLEAR,
    ST_START,
    ST_WAIT
  } state_t;

  function automatic logic [9:0] cell_index(input logic [4:0] row, input logic [4:0] col);
    return 10'(row) * 10'(GRID) + 10'(col);
  endfunction
endpackage

// File: rtl/canvas_pixel_map.sv
// Combinational screen-pixel to grid-cell mapping with range qualification.
module canvas_pixel_map
  import canvas_pkg::*;
#(
  parameter int ORIGIN_X   = 80,
  parameter int ORIGIN_Y   = 0,
  parameter int CELL_SHIFT = 4
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [4:0] row,
  output logic [4:0] col,
  output logic       in_range
);
  logic [10:0] diff_x;
  logic [10:0] diff_y;
  logic [9:0]  col_full;
  logic [9:0]  row_full;

  always_comb begin
    // The extra top bit acts as the borrow, so it flags a sample left of or above the origin.
    diff_x   = {1'b0, x} - 11'(ORIGIN_X);
    diff_y   = {1'b0, y} - 11'(ORIGIN_Y);
    col_full = diff_x[9:0] >> CELL_SHIFT;
    row_full = diff_y[9:0] >> CELL_SHIFT;
    col      = col_full[4:0];
    row      = row_full[4:0];
    in_range = !diff_x[10] && !diff_y[10] &&
               (col_full < 10'(GRID)) && (row_full < 10'(GRID));
  end
endmodule

// File: rtl/handwrite_canvas.sv
// 30x30 handwriting bitmap: paints a square brush per pen sample, clears
// row by row, and freezes while the digit recognizer is scoring it.
module handwrite_canvas
  import canvas_pkg::*;
#(
  parameter int ORIGIN_X   = 80,
  parameter int ORIGIN_Y   = 0,
  parameter int CELL_SHIFT = 4,
  parameter int BRUSH_R    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pen_valid,
  output logic                 o_pen_ready,
  input  logic [9:0]           i_pen_x,
  input  logic [9:0]           i_pen_y,
  input  logic                 i_clear,
  input  logic                 i_recognize,
  input  logic                 i_digit_valid,
  output logic                 o_button_pressed_n,
  output logic [GRID_BITS-1:0] o_handwrite,
  output logic                 o_locked
);
  localparam int SPAN = 2 * BRUSH_R + 1;
  localparam int CW   = $clog2(SPAN + 1);
  localparam logic [CW-1:0] LAST = CW'(SPAN - 1);

  state_t                 state_reg, state_next;
  logic [GRID_BITS-1:0]   handwrite_reg;
  logic [4:0]             center_row_reg, center_col_reg;
  logic [CW-1:0]          dy_reg, dx_reg;
  logic [4:0]             clr_row_reg;

  logic [4:0]             map_row, map_col;
  logic                   map_in_range;
  int                     tgt_row, tgt_col;
  logic                   paint_ok;
  logic [9:0]             paint_idx;
  logic                   paint_last;

  canvas_pixel_map #(
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y),
    .CELL_SHIFT(CELL_SHIFT)
  ) u_pixel_map (
    .x       (i_pen_x),
    .y       (i_pen_y),
    .row     (map_row),
    .col     (map_col),
    .in_range(map_in_range)
  );

  always_comb begin
    tgt_row    = int'(center_row_reg) + int'(dy_reg) - BRUSH_R;
    tgt_col    = int'(center_col_reg) + int'(dx_reg) - BRUSH_R;
    paint_ok   = (tgt_row >= 0) && (tgt_row < GRID) && (tgt_col >= 0) && (tgt_col < GRID);
    paint_idx  = cell_index(tgt_row[4:0], tgt_col[4:0]);
    paint_last = (dy_reg == LAST) && (dx_reg == LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_clear)                          state_next = ST_CLEAR;
        else if (i_recognize)                 state_next = ST_START;
        else if (i_pen_valid && map_in_range) state_next = ST_PAINT;
      end
      ST_PAINT: if (paint_last)               state_next = ST_IDLE;
      ST_CLEAR: if (clr_row_reg == 5'(GRID - 1)) state_next = ST_IDLE;
      ST_START:                               state_next = ST_WAIT;
      ST_WAIT:  if (i_digit_valid)            state_next = ST_IDLE;
      default:                                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      handwrite_reg  <= '0;
      center_row_reg <= '0;
      center_col_reg <= '0;
      dy_reg         <= '0;
      dx_reg         <= '0;
      clr_row_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Capturing every IDLE cycle is harmless: PAINT is only entered on an accepted sample.
          center_row_reg <= map_row;
          center_col_reg <= map_col;
          dy_reg         <= '0;
          dx_reg         <= '0;
          clr_row_reg    <= '0;
        end
        ST_PAINT: begin
          if (paint_ok) handwrite_reg[paint_idx] <= 1'b1;
          if (dx_reg == LAST) begin
            dx_reg <= '0;
            dy_reg <= dy_reg + 1'b1;
          end else begin
            dx_reg <= dx_reg + 1'b1;
          end
        end
        ST_CLEAR: begin
          handwrite_reg[cell_index(clr_row_reg, 5'd0) +: GRID] <= '0;
          clr_row_reg <= clr_row_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_handwrite        = handwrite_reg;
  assign o_pen_ready        = (state_reg == ST_IDLE);
  assign o_button_pressed_n = (state_reg != ST_START);
  assign o_locked           = (state_reg == ST_WAIT);
endmodule

// File: tb/tb_handwrite_canvas.sv
// Directed bench for handwrite_canvas: painting, drops, clear, recognize
// lock-out and asynchronous reset during a brush stroke.
module tb_handwrite_canvas;
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_pen_valid = 1'b0;
  logic         o_pen_ready;
  logic [9:0]   i_pen_x = '0;
  logic [9:0]   i_pen_y = '0;
  logic         i_clear = 1'b0;
  logic         i_recognize = 1'b0;
  logic         i_digit_valid = 1'b0;
  logic         o_button_pressed_n;
  logic [899:0] o_handwrite;
  logic         o_locked;

  logic [899:0] exp_map;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 i_clk = ~i_clk;

  handwrite_canvas #(
    .ORIGIN_X(80), .ORIGIN_Y(0), .CELL_SHIFT(4), .BRUSH_R(1)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_pen_valid       (i_pen_valid),
    .o_pen_ready       (o_pen_ready),
    .i_pen_x           (i_pen_x),
    .i_pen_y           (i_pen_y),
    .i_clear           (i_clear),
    .i_recognize       (i_recognize),
    .i_digit_valid     (i_digit_valid),
    .o_button_pressed_n(o_button_pressed_n),
    .o_handwrite       (o_handwrite),
    .o_locked          (o_locked)
  );

  // Presents one pen sample for a cycle, then counts negedges with ready low.
  task automatic send_pen(input int x, input int y, output int low_cycles);
    @(negedge i_clk);
    i_pen_valid = 1'b1;
    i_pen_x = 10'(x);
    i_pen_y = 10'(y);
    @(negedge i_clk);
    i_pen_valid = 1'b0;
    low_cycles = 0;
    while (!o_pen_ready && low_cycles < 60) begin
      low_cycles++;
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (o_handwrite !== '0) begin
      n_fail++; $display("FAIL reset_bitmap got=%h required=0", o_handwrite);
    end
    n_checks++;
    if ({o_pen_ready, o_button_pressed_n, o_locked} !== 3'b110) begin
      n_fail++; $display("FAIL reset_flags got=%b required=110", {o_pen_ready, o_button_pressed_n, o_locked});
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    $display("reset: ready=%b button_n=%b locked=%b", o_pen_ready, o_button_pressed_n, o_locked);
  endtask

  task automatic test_pen_corners();
    int cnt;
    send_pen(80, 0, cnt);
    exp_map = '0;
    exp_map[0] = 1'b1; exp_map[1] = 1'b1; exp_map[30] = 1'b1; exp_map[31] = 1'b1;
    $display("pen (80,0): ready low %0d cycles", cnt);
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL corner0_ready_low got=%0d required=9", cnt); end
    n_checks++;
    if (o_handwrite !== exp_map) begin
      n_fail++; $display("FAIL corner0_bitmap got=%h required=%h", o_handwrite, exp_map);
    end
    send_pen(559, 479, cnt);
    exp_map[868] = 1'b1; exp_map[869] = 1'b1; exp_map[898] = 1'b1; exp_map[899] = 1'b1;
    $display("pen (559,479): ready low %0d cycles", cnt);
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL corner29_ready_low got=%0d required=9", cnt); end
    n_checks++;
    if (o_handwrite !== exp_map) begin
      n_fail++; $display("FAIL corner29_bitmap got=%h required=%h", o_handwrite, exp_map);
    end
  endtask

  task automatic test_dropped();
    int cnt;
    send_pen(79, 10, cnt);
    $display("pen (79,10): ready low %0d cycles", cnt);
    n_checks++;
    if (cnt !== 0) begin n_fail++; $display("FAIL drop_left_ready got=%0d required=0", cnt); end
    send_pen(560, 0, cnt);
    $display("pen (560,0): ready low %0d cycles", cnt);
    n_checks++;
    if (cnt !== 0) begin n_fail++; $display("FAIL drop_right_ready got=%0d required=0", cnt); end
    n_checks++;
    if (o_handwrite !== exp_map) begin
      n_fail++; $display("FAIL drop_bitmap got=%h required=%h", o_handwrite, exp_map);
    end
  endtask

  task automatic test_clear();
    int cnt;
    send_pen(200, 200, cnt);
    exp_map[336] = 1'b1; exp_map[337] = 1'b1; exp_map[338] = 1'b1;
    exp_map[366] = 1'b1; exp_map[367] = 1'b1; exp_map[368] = 1'b1;
    exp_map[396] = 1'b1; exp_map[397] = 1'b1; exp_map[398] = 1'b1;
    $display("pen (200,200): ready low %0d cycles", cnt);
    n_checks++;
    if (o_handwrite !== exp_map) begin
      n_fail++; $display("FAIL mid_bitmap got=%h required=%h", o_handwrite, exp_map);
    end
    @(negedge i_clk);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    cnt = 0;
    while (!o_pen_ready && cnt < 60) begin
      cnt++;
      @(negedge i_clk);
    end
    exp_map = '0;
    $display("clear: ready low %0d cycles", cnt);
    n_checks++;
    if (cnt !== 30) begin n_fail++; $display("FAIL clear_ready_low got=%0d required=30", cnt); end
    n_checks++;
    if (o_handwrite !== exp_map) begin
      n_fail++; $display("FAIL clear_bitmap got=%h required=0", o_handwrite);
    end
  endtask

  task automatic test_recognize();
    int cnt;
    int bad;
    send_pen(80, 0, cnt);
    exp_map[0] = 1'b1; exp_map[1] = 1'b1; exp_map[30] = 1'b1; exp_map[31] = 1'b1;
    @(negedge i_clk);
    i_recognize = 1'b1;
    @(negedge i_clk);
    i_recognize = 1'b0;
    $display("recognize start: button_n=%b locked=%b", o_button_pressed_n, o_locked);
    n_checks++;
    if ({o_button_pressed_n, o_locked, o_pen_ready} !== 3'b000) begin
      n_fail++; $display("FAIL start_pulse got=%b required=000", {o_button_pressed_n, o_locked, o_pen_ready});
    end
    @(negedge i_clk);
    n_checks++;
    if ({o_button_pressed_n, o_locked} !== 2'b11) begin
      n_fail++; $display("FAIL wait_entry got=%b required=11", {o_button_pressed_n, o_locked});
    end
    // Hammer every request while locked; none of them may be honoured.
    i_pen_valid = 1'b1; i_pen_x = 10'd200; i_pen_y = 10'd200;
    i_clear = 1'b1; i_recognize = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (!o_locked || !o_button_pressed_n || o_pen_ready) bad++;
    end
    i_pen_valid = 1'b0; i_clear = 1'b0; i_recognize = 1'b0;
    $display("wait lock-out: %0d bad cycles", bad);
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL wait_held got=%0d required=0", bad); end
    n_checks++;
    if (o_handwrite !== exp_map) begin
      n_fail++; $display("FAIL wait_bitmap got=%h required=%h", o_handwrite, exp_map);
    end
    @(negedge i_clk);
    i_digit_valid = 1'b1;
    @(negedge i_clk);
    i_digit_valid = 1'b0;
    $display("digit valid: locked=%b ready=%b", o_locked, o_pen_ready);
    n_checks++;
    if ({o_locked, o_pen_ready, o_button_pressed_n} !== 3'b011) begin
      n_fail++; $display("FAIL release got=%b required=011", {o_locked, o_pen_ready, o_button_pressed_n});
    end
    n_checks++;
    if (o_handwrite !== exp_map) begin
      n_fail++; $display("FAIL release_bitmap got=%h required=%h", o_handwrite, exp_map);
    end
  endtask

  task automatic test_reset_mid_paint();
    int cnt;
    logic [899:0] partial;
    @(negedge i_clk);
    i_pen_valid = 1'b1; i_pen_x = 10'd200; i_pen_y = 10'd200;
    @(negedge i_clk);
    i_pen_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    partial = exp_map;
    partial[336] = 1'b1; partial[337] = 1'b1; partial[338] = 1'b1; partial[366] = 1'b1;
    n_checks++;
    if (o_handwrite !== partial) begin
      n_fail++; $display("FAIL partial_bitmap got=%h required=%h", o_handwrite, partial);
    end
    i_rst_n = 1'b0;
    #1;
    $display("reset mid-paint: ready=%b button_n=%b locked=%b", o_pen_ready, o_button_pressed_n, o_locked);
    n_checks++;
    if ({o_pen_ready, o_button_pressed_n, o_locked} !== 3'b110) begin
      n_fail++; $display("FAIL abort_flags got=%b required=110", {o_pen_ready, o_button_pressed_n, o_locked});
    end
    n_checks++;
    if (o_handwrite !== '0) begin
      n_fail++; $display("FAIL abort_bitmap got=%h required=0", o_handwrite);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    send_pen(80, 0, cnt);
    exp_map = '0;
    exp_map[0] = 1'b1; exp_map[1] = 1'b1; exp_map[30] = 1'b1; exp_map[31] = 1'b1;
    $display("pen (80,0) after reset: ready low %0d cycles", cnt);
    n_checks++;
    if (cnt !== 9) begin n_fail++; $display("FAIL repaint_ready_low got=%0d required=9", cnt); end
    n_checks++;
    if (o_handwrite !== exp_map) begin
      n_fail++; $display("FAIL repaint_bitmap got=%h required=%h", o_handwrite, exp_map);
    end
  endtask

  initial begin
    test_reset();
    test_pen_corners();
    test_dropped();
    test_clear();
    test_recognize();
    test_reset_mid_paint();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
